// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES definitions for the encrypt and decrypt cores:
//   - FSM state encoding
//   - IP, FP, E, P, PC1 and PC2 index tables (1-based DES bit numbers)
//   - S-box contents and the decrypt-direction key rotation schedule
//   - permutation helpers that are pure wiring driven by the tables
// Bit-order convention: DES bit n of a W-bit quantity is vector bit W-n,
// so DES bit 1 is always the MSB.
// -----------------------------------------------------------------------------
package des_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int N_ROUNDS = 16;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits (8, 16, ..., 64) never appear here, so they are dropped.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Right-rotation amount applied to C and D before forming the subkey of
    // decrypt round r. Round 0 uses the PC1 value directly (that is K16).
    localparam logic [1:0] SHR_TBL [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // S-box rows, entry index = {box[2:0], row[1:0]}; column 0 is the
    // most significant nibble of each 64-bit row.
    localparam logic [63:0] SBOX_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
        return y;
    endfunction

    // Outer bits (b1, b6) select the row, inner bits (b2..b5) the column.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        logic [63:0] row_bits;
        logic [3:0]  col;
        row_bits = SBOX_ROWS[{box, b[5], b[0]}];
        col      = b[4:1];
        return row_bits[{~col, 2'b00} +: 4];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[0],   x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage : des_pkg

// File: rtl/des_f.sv
// -----------------------------------------------------------------------------
// des_f
// DES round function f(R, K): E expansion, subkey XOR, S1..S8, P permutation.
// Purely combinational; shared by the encrypt and decrypt cores.
// Ports:
//   r_i  [31:0]  right half of the Feistel state
//   k_i  [47:0]  round subkey
//   f_o  [31:0]  f(R, K)
// -----------------------------------------------------------------------------
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mixed;
    logic [31:0] s_out;

    assign mixed = e_perm(r_i) ^ k_i;

    // S-box i consumes 6-bit group i (MSB first) and yields nibble i.
    always_comb begin
        s_out = '0;
        for (int i = 0; i < 8; i++) begin
            s_out[31-4*i -: 4] = sbox_lookup(3'(i), mixed[47-6*i -: 6]);
        end
    end

    assign f_o = p_perm(s_out);

endmodule : des_f

// File: rtl/des_decrypt_core.sv
// -----------------------------------------------------------------------------
// des_decrypt_core
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// generated on the fly by right-rotating C and D. 16 cycles from accept to
// out_valid; one idle cycle after each output transfer.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   ct  [63:0]            ciphertext, bit 63 = DES bit 1
//   key [63:0]            key incl. ignored parity bits, bit 63 = DES bit 1
//   out_valid / out_ready output handshake; out_valid is high only in DONE
//   pt  [63:0]            plaintext, held stable while out_valid is high
// -----------------------------------------------------------------------------
module des_decrypt_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt
);

    logic [1:0]  state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pt_q, pt_d;

    logic [63:0] ip_blk;
    logic [55:0] cd_init;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;
    logic [31:0] l_new, r_new;

    // Load-path permutations of the incoming block and key
    assign ip_blk  = ip_perm(ct);
    assign cd_init = pc1_perm(key);

    // Key schedule: rotate first, then compress; the rotated C/D are stored
    assign c_rot  = rotr28(c_q, SHR_TBL[cnt_q]);
    assign d_rot  = rotr28(d_q, SHR_TBL[cnt_q]);
    assign subkey = pc2_perm({c_rot, d_rot});

    des_f u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    assign l_new = r_q;
    assign r_new = l_q ^ f_out;

    always_comb begin
        // NOTE: every next-state signal first takes its held value, so no branch
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_blk[63:32];
                    r_d     = ip_blk[31:0];
                    c_d     = cd_init[55:28];
                    d_d     = cd_init[27:0];
                    cnt_d   = 4'd0;
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                l_d   = l_new;
                r_d   = r_new;
                c_d   = c_rot;
                d_d   = d_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(N_ROUNDS - 1)) begin
                    // Last round: the halves are swapped before FP
                    pt_d    = fp_perm({r_new, l_new});
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
        end
    end

    // Handshake outputs depend on state only
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign pt        = pt_q;

endmodule : des_decrypt_core

// File: tb/tb_des_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_core
// Scoreboard bench for des_decrypt_core: the driver pushes expected plaintext
// and accept edge on each accepted block; an independent monitor pops and
// compares on every output transfer and checks latency and stall stability.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_des_decrypt_core;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ct;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pt;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY2P = 64'h0F339333EB6C0C72; // parity bits flipped
    localparam logic [63:0] CT2  = 64'h0000000000000000;
    localparam logic [63:0] PT2  = 64'h8787878787878787;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];
    int          acc_log[$];

    des_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Independent encrypt-direction reference (left shifts, K1..K16)
    function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [63:0] k);
        logic [63:0] x, y;
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [31:0] l, r, t, s, fo;
        logic [47:0] ks, er;
        logic [5:0]  six;
        logic [63:0] rowv;
        int          sh, col, row;
        for (int i = 0; i < 64; i++) x[63-i] = p[64-IP_TBL[i]];
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_TBL[i]];
        c = cd[55:28];
        d = cd[27:0];
        l = x[63:32];
        r = x[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            sh = (rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2;
            for (int j = 0; j < sh; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[47-i] = cd[56-PC2_TBL[i]];
            for (int i = 0; i < 48; i++) er[47-i] = r[32-E_TBL[i]];
            er = er ^ ks;
            for (int b = 0; b < 8; b++) begin
                six  = er[47-6*b -: 6];
                row  = {30'd0, six[5], six[0]};
                col  = {28'd0, six[4:1]};
                rowv = SBOX_ROWS[b*4+row];
                s[31-4*b -: 4] = rowv[63-4*col -: 4];
            end
            for (int i = 0; i < 32; i++) fo[31-i] = s[32-P_TBL[i]];
            t = r;
            r = l ^ fo;
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
        return y;
    endfunction

    // Offer a block and wait (bounded) for it to be accepted
    task automatic send(input logic [63:0] c, input logic [63:0] k, input logic [63:0] e);
        int waited;
        waited   = 0;
        ct       = c;
        key      = k;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            acc_log.push_back(cyc + 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Let all outstanding results drain with out_ready held high
    task automatic drain(input int budget);
        int n;
        n         = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    // Monitor / scoreboard
    initial begin
        logic        ov_prev;
        logic [63:0] pt_prev;
        ov_prev = 1'b0;
        pt_prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid) begin
                    check("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
                    if (!ov_prev) begin
                        if (acc_q.size() == 0) fail("unexpected_out_valid");
                        else check("latency", 64'(cyc - acc_q.pop_front()), 64'd16);
                    end else begin
                        check("pt_stable_in_stall", pt, pt_prev);
                    end
                    if (out_ready) begin
                        if (exp_q.size() == 0) fail("unexpected_transfer");
                        else check("pt", pt, exp_q.pop_front());
                    end
                end
                ov_prev = out_valid;
                pt_prev = pt;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation did not finish");
    end

    // Stimulus
    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct        = '0;
        key       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_pt",        pt,                 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("model_kat1", ref_encrypt(PT1, KEY1), CT1);
        check("model_kat2", ref_encrypt(PT2, KEY2), CT2);

        // Known answers, parity-insensitive key
        out_ready = 1'b1;
        send(CT1, KEY1, PT1);
        drain(100);
        send(CT2, KEY2, PT2);
        drain(100);
        send(CT2, KEY2P, PT2);
        drain(100);

        // Back-pressure: 10 stalled cycles in DONE with ignored input pulses
        out_ready = 1'b0;
        send(CT1, KEY1, PT1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail("bp_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            ct       = {$urandom, $urandom};
            key      = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", {63'd0, in_ready},  64'd1);
        check("bp_out_valid_after", {63'd0, out_valid}, 64'd0);

        // Back-to-back with in_valid and out_ready held high
        acc_log.delete();
        send(CT1, KEY1, PT1);
        send(CT2, KEY2, PT2);
        send(CT2, KEY2P, PT2);
        drain(200);
        if (acc_log.size() == 3) begin
            check("b2b_spacing_0", 64'(acc_log[1] - acc_log[0]), 64'd18);
            check("b2b_spacing_1", 64'(acc_log[2] - acc_log[1]), 64'd18);
        end else begin
            fail("b2b_accept_count");
        end

        // Reset during round 7
        send(CT2, KEY2, PT2);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("rst_busy_before", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_pt",        pt,                 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(CT1, KEY1, PT1);
        drain(100);

        // Round trip against the encrypt reference
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] rk, rp;
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            send(ref_encrypt(rp, rk), rk, rp);
        end
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_des_decrypt_core
